fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one FIFO among `NREQ` requesters in the write clock domain. Each requester presents words with a valid/ready handshake. The arbiter grants one requester at a time for a burst, which ends on the requester's `last` flag or after `MAXBURST` words. It drives the FIFO `wdata`/`winc` pins and honours `wfull` backpressure.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `DSIZE`, 8: data width; matches the FIFO `DSIZE`.
- `MAXBURST`, 4: maximum words per grant, ≥1.

- `wclk`  in  1  write-domain clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester word valid.
- `req_data`  in  NREQ*DSIZE  requester i's data at bits [i*DSIZE +: DSIZE].
- `req_last`  in  NREQ  marks the final word of a requester's packet.
- `req_ready`  out  NREQ  per-requester accept; a word transfers when `req_valid[i] & req_ready[i]`.
- `fifo_wdata`  out  DSIZE  to the FIFO `wdata`.
- `fifo_winc`  out  1  to the FIFO `winc`.
- `fifo_wfull`  in  1  from the FIFO `wfull`.
- `grant_id`  out  max(1,$clog2(NREQ))  index of the current or last granted requester.
- `busy`  out  1  high while in BURST.

## Operation
- FSM states:
  - IDLE to ARB when any `req_valid` is high; otherwise stay in IDLE.
  - ARB to BURST, always, after exactly one cycle.
  - BURST to IDLE on the terminating transfer.
- ARB:
  - Picks the first requester with `req_valid` high, searching from `rr_ptr` upward and wrapping modulo `NREQ`.
  - Registers the winner into `grant_id` and clears `burst_cnt`.
  - If no `req_valid` is high in ARB (a requester withdrew), return to IDLE; `grant_id` is unchanged.
- BURST outputs:
  - `req_ready[grant_id] = !fifo_wfull`; all other `req_ready` bits are 0.
  - `fifo_winc = req_valid[grant_id] & !fifo_wfull`.
  - `fifo_wdata = req_data[grant_id]` (combinational mux).
- Each transfer increments `burst_cnt`.
- A transfer is terminating if `req_last[grant_id]` is high, or if `burst_cnt == MAXBURST-1`.
- On a terminating transfer, `rr_ptr <= (grant_id+1) mod NREQ`.
- Grant is held while the granted requester has `req_valid` low: no transfer, no count, no timeout. Requesters must not abandon a burst.
- `fifo_wfull` high: `req_ready` and `fifo_winc` are 0, the word is held, and `burst_cnt` is frozen.
- Outside BURST: `fifo_winc` = 0 and all `req_ready` = 0. `fifo_wdata` is don't-care but is driven as `req_data[grant_id]`.
- Widths:
  - `burst_cnt` is $clog2(MAXBURST+1) bits.
  - `rr_ptr` and `grant_id` wrap modulo `NREQ`; non-power-of-2 `NREQ` wraps explicitly.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.

## Timing
- Reset (`rst` low, async):
  - State IDLE; `rr_ptr`, `grant_id`, `burst_cnt` all 0.
  - `busy` = 0, `fifo_winc` = 0, `req_ready` = 0.
  - Effective immediately, including mid-burst.
  - Words already written remain in the FIFO; the partial packet is not completed.
- Latency from first `req_valid` in IDLE to first possible transfer: 2 cycles (IDLE→ARB edge, ARB→BURST edge).
- Throughput inside a burst: one word per cycle when valid and not full.
- Per-burst overhead: 2 dead cycles (IDLE + ARB) between bursts.
- `fifo_winc` and `req_ready` are combinational from state, `grant_id`, `req_valid` and `fifo_wfull`.
- `fifo_wfull` is the FIFO's registered flag, so there is no combinational loop.
- `busy` is registered and equals (state == BURST).
- A new request arriving in BURST does not preempt the burst; it is considered at the next ARB.

## Test plan
- Reset:
  - Stimulus: assert `rst`=0 mid-burst with `req_valid`=4'b1111.
  - Required: same cycle `fifo_winc`=0, `req_ready`=0, `busy`=0; after release, the first grant is `grant_id`=0.
- Round-robin:
  - Stimulus: `NREQ`=4, all valid, single-word packets (`req_last`=1), data = 8'hA0+i.
  - Required: FIFO receives A0,A1,A2,A3,A0; each write is 3 cycles apart.
- Burst cap:
  - Stimulus: requester 2 alone, 6 words 8'h10..8'h15, `req_last` only on the last word, `MAXBURST`=4.
  - Required: 10,11,12,13 in one grant; then IDLE→ARB re-grants requester 2 for 14,15.
- Backpressure:
  - Stimulus: `fifo_wfull`=1 for 3 cycles mid-burst.
  - Required: `fifo_winc`=0 and `req_ready`=0 throughout; `burst_cnt` unchanged; the word is written exactly once after `fifo_wfull` falls.
- Granted requester stalls:
  - Stimulus: granted requester 1 drops `req_valid` for 2 cycles while requester 3 is valid.
  - Required: grant stays on 1, no writes occur, and the burst resumes.
- Withdrawal in ARB:
  - Stimulus: `req_valid` pulses for one cycle only in IDLE.
  - Required: ARB→IDLE, no write, `grant_id` unchanged, `rr_ptr` unchanged.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Bursts end on the requester's last flag or after MAXBURST words.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                                    wclk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req_valid,
    input  logic [NREQ*DSIZE-1:0]                   req_data,
    input  logic [NREQ-1:0]                         req_last,
    output logic [NREQ-1:0]                         req_ready,
    output logic [DSIZE-1:0]                        fifo_wdata,
    output logic                                    fifo_winc,
    input  logic                                    fifo_wfull,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                                    busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_BURST
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_grant_id;
    logic [CW-1:0]   r_burst_cnt;
    logic            r_busy;

    logic [DSIZE-1:0] w_data [NREQ];
    logic             w_found;
    logic [GW-1:0]    w_pick;
    logic             w_gvalid;
    logic             w_glast;
    logic             w_xfer;
    logic             w_term;
    logic [GW-1:0]    w_next_gid;

    // Split the flat data bus into one word per requester
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_data[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        int          v_idx;
        logic [GW-1:0] v_sel;
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        v_idx   = 0;
        v_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            v_sel = GW'(v_idx);
            if (!w_found && req_valid[v_sel]) begin
                w_found = 1'b1;
                w_pick  = v_sel;
            end
        end
    end

    assign w_gvalid   = req_valid[r_grant_id];
    assign w_glast    = req_last[r_grant_id];
    assign fifo_wdata = w_data[r_grant_id];
    assign fifo_winc  = (r_state == S_BURST) & w_gvalid & ~fifo_wfull;
    assign w_xfer     = fifo_winc;
    assign w_term     = w_glast | (r_burst_cnt == CW'(MAXBURST - 1));
    assign w_next_gid = (r_grant_id == GW'(NREQ - 1)) ? '0
                                                      : r_grant_id + 1'b1;
    assign grant_id   = r_grant_id;
    assign busy       = r_busy;

    // Only the granted requester sees ready, and only while FIFO has room
    always_comb begin
        req_ready = '0;
        if (r_state == S_BURST && !fifo_wfull) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    // Arbitration FSM: IDLE -> ARB -> BURST, with registered busy flag
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_found) begin
                        r_grant_id  <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= S_BURST;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (w_term) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= w_next_gid;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle model compare plus
// hand-computed literal checks on the write log.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 4;
    localparam int GW       = 2;
    localparam int DEPTH    = 64;

    logic                    wclk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*DSIZE-1:0]   req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic [DSIZE-1:0]        fifo_wdata;
    logic                    fifo_winc;
    logic                    fifo_wfull;
    logic [GW-1:0]           grant_id;
    logic                    busy;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)
    ) dut (
        .wclk(wclk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_wdata(fifo_wdata),
        .fifo_winc(fifo_winc), .fifo_wfull(fifo_wfull),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dut_wr = 0;

    // source queues per requester: {last, data}
    logic [8:0]      src_mem [NREQ][DEPTH];
    int              src_wr  [NREQ];
    int              src_rd  [NREQ];
    logic [NREQ-1:0] hold;
    logic [NREQ-1:0] pop_pend;

    // model state: phase 0 idle, 1 arbitrate, 2 burst
    int m_st, m_ptr, m_gid, m_cnt;

    typedef struct {
        logic [7:0] d;
        int         g;
        int         c;
    } wr_t;
    wr_t log_q[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            logic [8:0] w;
            w = (src_rd[i] < src_wr[i]) ? src_mem[i][src_rd[i]] : 9'h0;
            req_valid[i] = (src_rd[i] < src_wr[i]) && !hold[i];
            req_last[i]  = w[8];
            req_data[i*DSIZE +: DSIZE] = w[7:0];
        end
    endtask

    task automatic push(int r, logic [7:0] d, logic l);
        src_mem[r][src_wr[r]] = {l, d};
        src_wr[r]++;
    endtask

    task automatic step();
        @(posedge wclk);
        #2;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) p = 1;
        end
        return p || (m_st != 0);
    endfunction

    task automatic wait_drain(string nm);
        int n = 0;
        while (pending() && n < 300) begin
            step();
            n++;
        end
        chk(nm, 32'(n < 300), 1);
    endtask

    task automatic wait_log(int target, string nm);
        int n = 0;
        while (log_q.size() < target && n < 100) begin
            step();
            n++;
        end
        chk(nm, 32'(n < 100), 1);
    endtask

    // model advance and source pops on the active edge
    always @(posedge wclk) begin
        bit found;
        cyc++;
        if (!rst) begin
            m_st = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
        end else begin
            case (m_st)
                0: if (req_valid != '0) m_st = 1;
                1: begin
                    found = 0;
                    for (int k = 0; k < NREQ; k++) begin
                        if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                            found = 1;
                            m_gid = (m_ptr + k) % NREQ;
                        end
                    end
                    if (found) begin
                        m_cnt = 0;
                        m_st  = 2;
                    end else begin
                        m_st = 0;
                    end
                end
                default: begin
                    if (req_valid[m_gid] && !fifo_wfull) begin
                        log_q.push_back('{req_data[m_gid*DSIZE +: DSIZE],
                                          m_gid, cyc});
                        if (req_last[m_gid] || m_cnt == MAXBURST - 1) begin
                            m_st  = 0;
                            m_ptr = (m_gid + 1) % NREQ;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
            endcase
            for (int i = 0; i < NREQ; i++) begin
                if (pop_pend[i]) src_rd[i]++;
            end
        end
        #1 refresh();
    end

    // per-cycle compare against the model, away from the active edge
    always @(negedge wclk) begin
        logic [NREQ-1:0] er;
        logic            ew;
        pop_pend = req_valid & req_ready;
        if (fifo_winc === 1'b1) dut_wr++;
        if (!rst) begin
            chk("rst_winc", 32'(fifo_winc), 0);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_busy", 32'(busy), 0);
        end else begin
            er = '0;
            if (m_st == 2 && !fifo_wfull) er[m_gid] = 1'b1;
            ew = (m_st == 2) && req_valid[m_gid] && !fifo_wfull;
            chk("busy", 32'(busy), 32'(m_st == 2));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("winc", 32'(fifo_winc), 32'(ew));
            chk("ready", 32'(req_ready), 32'(er));
            if (ew) begin
                chk("wdata", 32'(fifo_wdata),
                    32'(src_mem[m_gid][src_rd[m_gid]][7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        rst        = 1'b1;
        fifo_wfull = 1'b0;
        hold       = '0;
        pop_pend   = '0;
        m_st = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        refresh();
        #1 rst = 1'b0;
        repeat (3) @(posedge wclk);
        #2 rst = 1'b1;
        @(negedge wclk);
        chk("reset_gid", 32'(grant_id), 0);
        chk("reset_busy", 32'(busy), 0);
        step();

        // round-robin with single-word packets
        b = log_q.size();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        end
        refresh();
        wait_drain("rr_drain");
        for (int k = 0; k < 8; k++) begin
            chk("rr_data", 32'(log_q[b+k].d), 32'(8'hA0 + 8'(k % 4)));
        end
        for (int k = 1; k < 5; k++) begin
            chk("rr_gap", 32'(log_q[b+k].c - log_q[b+k-1].c), 3);
        end

        // burst cap: requester 2 alone, six words
        b = log_q.size();
        for (int j = 0; j < 6; j++) push(2, 8'h10 + 8'(j), 1'(j == 5));
        refresh();
        wait_drain("cap_drain");
        for (int k = 0; k < 6; k++) begin
            chk("cap_data", 32'(log_q[b+k].d), 32'(8'h10 + 8'(k)));
            chk("cap_gid", 32'(log_q[b+k].g), 2);
        end
        chk("cap_gap0", 32'(log_q[b+1].c - log_q[b].c), 1);
        chk("cap_gap3", 32'(log_q[b+3].c - log_q[b+2].c), 1);
        chk("cap_regrant", 32'(log_q[b+4].c - log_q[b+3].c), 3);

        // backpressure for three cycles after the first word
        b = log_q.size();
        for (int j = 0; j < 4; j++) push(0, 8'h20 + 8'(j), 1'(j == 3));
        refresh();
        wait_log(b + 1, "bp_first");
        fifo_wfull = 1'b1;
        step();
        step();
        step();
        fifo_wfull = 1'b0;
        wait_drain("bp_drain");
        chk("bp_count", 32'(log_q.size() - b), 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_data", 32'(log_q[b+k].d), 32'(8'h20 + 8'(k)));
        end
        chk("bp_gap", 32'(log_q[b+1].c - log_q[b].c), 4);
        chk("bp_gap2", 32'(log_q[b+2].c - log_q[b+1].c), 1);

        // granted requester 1 stalls while requester 3 waits
        b = log_q.size();
        push(1, 8'h30, 1'b0);
        push(1, 8'h31, 1'b0);
        push(1, 8'h32, 1'b1);
        push(3, 8'h40, 1'b1);
        refresh();
        wait_log(b + 1, "stall_first");
        hold[1] = 1'b1;
        refresh();
        step();
        step();
        hold[1] = 1'b0;
        refresh();
        wait_drain("stall_drain");
        chk("stall_d0", 32'(log_q[b].d), 32'h30);
        chk("stall_d1", 32'(log_q[b+1].d), 32'h31);
        chk("stall_d2", 32'(log_q[b+2].d), 32'h32);
        chk("stall_d3", 32'(log_q[b+3].d), 32'h40);
        chk("stall_g1", 32'(log_q[b+1].g), 1);
        chk("stall_g3", 32'(log_q[b+3].g), 3);
        chk("stall_gap", 32'(log_q[b+1].c - log_q[b].c), 3);

        // one-cycle valid pulse withdraws before arbitration
        b = log_q.size();
        push(0, 8'h50, 1'b1);
        refresh();
        step();
        hold[0] = 1'b1;
        refresh();
        step();
        step();
        step();
        chk("wd_nowrite", 32'(log_q.size() - b), 0);
        chk("wd_gid", 32'(grant_id), 3);
        chk("wd_busy", 32'(busy), 0);
        push(2, 8'h60, 1'b1);
        hold[0] = 1'b0;
        refresh();
        wait_drain("wd_drain");
        chk("wd_first", 32'(log_q[b].d), 32'h50);
        chk("wd_first_g", 32'(log_q[b].g), 0);
        chk("wd_second", 32'(log_q[b+1].d), 32'h60);

        // reset in the middle of a burst with all requesters valid
        b = log_q.size();
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < 3; j++) begin
                push(i, 8'h70 + 8'(i*4 + j), 1'(j == 2));
            end
        end
        refresh();
        wait_log(b + 1, "mr_first");
        chk("mr_first_g", 32'(log_q[b].g), 3);
        step();
        rst = 1'b0;
        @(negedge wclk);
        chk("mr_winc", 32'(fifo_winc), 0);
        chk("mr_ready", 32'(req_ready), 0);
        chk("mr_busy", 32'(busy), 0);
        step();
        step();
        rst = 1'b1;
        b = log_q.size();
        wait_drain("mr_drain");
        chk("mr_regrant", 32'(log_q[b].g), 0);
        chk("mr_regrant_d", 32'(log_q[b].d), 32'h70);
        repeat (3) step();
        chk("total_writes", 32'(dut_wr), 32'(log_q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
